// File: rtl/div_sign_seq_if.sv
// Handshake and operand/result bundle for the sequential signed/unsigned divider.
`timescale 1ns/1ps
interface div_sign_seq_if #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
);
  logic         start;
  logic         sg;
  logic [N-1:0] A;
  logic [M-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Q;
  logic [M-1:0] R;
  logic         dz;
  logic         ovf;

  modport master (
    output start, sg, A, B,
    input  busy, done, Q, R, dz, ovf
  );

  modport slave (
    input  start, sg, A, B,
    output busy, done, Q, R, dz, ovf
  );
endinterface

// File: rtl/div_sign_seq.sv
// Sequential restoring divider: one quotient bit per clock on operand
// magnitudes, signs reapplied in a final fix-up cycle. Latency N+1 cycles.
`timescale 1ns/1ps
module div_sign_seq #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  div_sign_seq_if.slave  bus
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          qneg_q, rneg_q, zero_q, ovfc_q;
  logic [N-1:0]  d_q;
  logic [N-1:0]  qm_q;
  logic [M-1:0]  p_q;
  logic [M-1:0]  bm_q;

  logic          busy_q, done_q, dz_q, ovf_q;
  logic [N-1:0]  q_q;
  logic [M-1:0]  r_q;

  logic [N-1:0]  a_mag_d;
  logic [M-1:0]  b_mag_d;
  logic [M:0]    t_d;
  logic          t_ge_d;
  logic [M-1:0]  p_d;
  logic          a_min_d;

  // Operand magnitudes and one restoring-division step.
  // The partial remainder is always < |B|, so it is kept in M bits;
  // only the trial value T needs the extra bit.
  always_comb begin
    a_mag_d = (bus.sg && bus.A[N-1]) ? (~bus.A + 1'b1) : bus.A;
    b_mag_d = (bus.sg && bus.B[M-1]) ? (~bus.B + 1'b1) : bus.B;
    a_min_d = (bus.A == {1'b1, {(N-1){1'b0}}});
    t_d     = {p_q, d_q[N-1]};
    t_ge_d  = (t_d >= {1'b0, bm_q});
    p_d     = t_ge_d ? M'(t_d - {1'b0, bm_q}) : t_d[M-1:0];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovfc_q  <= 1'b0;
      d_q     <= '0;
      qm_q    <= '0;
      p_q     <= '0;
      bm_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            qneg_q  <= bus.sg & (bus.A[N-1] ^ bus.B[M-1]);
            rneg_q  <= bus.sg & bus.A[N-1];
            zero_q  <= (bus.B == '0);
            ovfc_q  <= bus.sg & a_min_d & (&bus.B);
            d_q     <= a_mag_d;
            bm_q    <= b_mag_d;
            p_q     <= '0;
            qm_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          d_q   <= d_q << 1;
          p_q   <= p_d;
          qm_q  <= {qm_q[N-2:0], t_ge_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N-1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
          if (zero_q) begin
            q_q   <= '1;
            r_q   <= '0;
            dz_q  <= 1'b1;
            ovf_q <= 1'b0;
          end else begin
            q_q   <= qneg_q ? (~qm_q + 1'b1) : qm_q;
            r_q   <= rneg_q ? (~p_q + 1'b1) : p_q;
            dz_q  <= 1'b0;
            ovf_q <= ovfc_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.dz   = dz_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_div_sign_seq.sv
// Scoreboard bench for div_sign_seq: driver pushes expected results computed
// with plain integer division; a monitor checks busy/done timing and results.
`timescale 1ns/1ps
module tb_div_sign_seq;

  localparam int unsigned N = 8;
  localparam int unsigned M = 4;

  typedef struct {
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         dz;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   busy_until;
  int   errors;
  int   checks;
  exp_t sb[$];
  exp_t cur;

  div_sign_seq_if #(.N(N), .M(M)) bus ();

  div_sign_seq #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t zero_exp();
    exp_t e;
    e.q = '0; e.r = '0; e.dz = 1'b0; e.ovf = 1'b0; e.cyc = 0;
    return e;
  endfunction

  // Truncating-division reference from integer arithmetic.
  function automatic exp_t model(input logic s, input logic [N-1:0] a, input logic [M-1:0] b);
    exp_t e;
    int ai, bi, qi, ri;
    e  = zero_exp();
    ai = s ? int'($signed(a)) : int'(a);
    bi = s ? int'($signed(b)) : int'(b);
    if (bi == 0) begin
      e.q  = '1;
      e.dz = 1'b1;
    end else if (s && ai == -(1 << (N-1)) && bi == -1) begin
      e.q   = {1'b1, {(N-1){1'b0}}};
      e.ovf = 1'b1;
    end else begin
      qi  = ai / bi;
      ri  = ai % bi;
      e.q = qi[N-1:0];
      e.r = ri[M-1:0];
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle, #1 after the rising edge.
  always @(posedge clk) begin
    #1;
    chk("busy", {31'd0, bus.busy}, (cyc <= busy_until) ? 32'd1 : 32'd0);
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      chk("done", {31'd0, bus.done}, 32'd1);
      cur = sb.pop_front();
    end else begin
      chk("done", {31'd0, bus.done}, 32'd0);
    end
    chk("Q",   {24'd0, bus.Q},   {24'd0, cur.q});
    chk("R",   {28'd0, bus.R},   {28'd0, cur.r});
    chk("dz",  {31'd0, bus.dz},  {31'd0, cur.dz});
    chk("ovf", {31'd0, bus.ovf}, {31'd0, cur.ovf});
  end

  // Called at a falling edge: start is sampled at the next rising edge.
  task automatic issue(input logic s, input logic [N-1:0] a, input logic [M-1:0] b);
    exp_t e;
    int   k;
    bus.sg    = s;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    k = cyc + 1;
    if (rst_n && k > busy_until) begin
      e     = model(s, a, b);
      e.cyc = k + N + 1;
      sb.push_back(e);
      busy_until = k + N;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.sg    = 1'($urandom);
    bus.A     = N'($urandom);
    bus.B     = M'($urandom);
  endtask

  // Advance to the falling edge of the cycle in which done is expected.
  task automatic wait_done();
    while (cyc < busy_until + 1) @(negedge clk);
  endtask

  task automatic assert_reset();
    rst_n      = 1'b0;
    sb.delete();
    busy_until = -1;
    cur        = zero_exp();
  endtask

  initial begin
    cyc        = 0;
    busy_until = -1;
    errors     = 0;
    checks     = 0;
    cur        = zero_exp();
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.sg     = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations from the plan.
    issue(1'b0, 8'd200, 4'd7);  wait_done();
    issue(1'b1, 8'h9C,  4'd7);  wait_done();
    issue(1'b1, 8'd100, 4'h9);  wait_done();
    issue(1'b1, 8'h80,  4'h8);  wait_done();
    issue(1'b0, 8'h55,  4'h0);  wait_done();
    issue(1'b1, 8'h55,  4'h0);  wait_done();
    issue(1'b1, 8'h80,  4'hF);  wait_done();
    issue(1'b1, 8'h10,  4'h3);  wait_done();
    issue(1'b0, 8'hFF,  4'h1);  wait_done();
    issue(1'b1, 8'h00,  4'hB);  wait_done();
    issue(1'b0, 8'h00,  4'h5);  wait_done();

    // Start mid-CALC with different operands is ignored.
    issue(1'b0, 8'd77, 4'd5);
    repeat (3) @(negedge clk);
    issue(1'b1, 8'hC3, 4'hD);
    wait_done();

    // Back-to-back: second start in the done cycle.
    issue(1'b1, 8'h7F, 4'h3);
    wait_done();
    issue(1'b0, 8'hE1, 4'h9);
    wait_done();

    // Reset in the middle of CALC aborts without a done pulse.
    issue(1'b0, 8'd123, 4'd6);
    repeat (4) @(negedge clk);
    assert_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b1, 8'hA5, 4'h6);
    wait_done();

    // Reset and start together: reset wins.
    @(negedge clk);
    assert_reset();
    issue(1'b0, 8'd50, 4'd3);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(1'b0, 8'd50, 4'd3);
    wait_done();

    // Randomised operations, occasional idle gaps.
    for (int i = 0; i < 3000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom), N'($urandom), M'($urandom));
      wait_done();
    end

    repeat (N + 3) @(negedge clk);
    chk("drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
